// File: rtl/ram_copy_engine.sv
// ram_copy_engine: initiator-side block copy / fill controller for a 64x8
// single-port RAM with a registered read address (q valid the cycle after a
// read address is presented with we=0).
//
// One word is moved per RD/WR pair for copy, or per WR cycle for fill.
// Overlapping copies with the destination above the source run top-down, so
// source words are read before they are overwritten.
module ram_copy_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic              desc_q, desc_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W:0]   wd_q, wd_d;

  logic [ADDR_W:0]   wd_inc;
  logic [ADDR_W:0]   offs;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   src_ext;
  logic [ADDR_W:0]   dst_ext;

  // Word offset of the current transfer and the truncated RAM addresses.
  always_comb begin
    wd_inc  = wd_q + 1'b1;
    offs    = desc_q ? (len_q - wd_q - 1'b1) : wd_q;
    rd_addr = src_q + offs[ADDR_W-1:0];
    wr_addr = dst_q + offs[ADDR_W-1:0];
    src_ext = {1'b0, src_addr};
    dst_ext = {1'b0, dst_addr};
  end

  // Next-state logic: command capture in IDLE, sequencing through RD/WR.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    desc_d  = desc_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = len;
          fill_d = fill_data;
          // Overlap with destination above source: copy top-down.
          desc_d = !mode && (dst_ext > src_ext) && (dst_ext < src_ext + len);
          wd_d   = '0;
          if (len == '0)  state_d = S_DONE;
          else if (mode)  state_d = S_WR;
          else            state_d = S_RD;
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        wd_d = wd_inc;
        if (wd_inc == len_q) state_d = S_DONE;
        else if (mode_q)     state_d = S_WR;
        else                 state_d = S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      desc_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      desc_q  <= desc_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      wd_q    <= wd_d;
    end
  end

  // RAM port and status outputs decoded from state; idle port is all-zero.
  always_comb begin
    busy       = (state_q == S_RD) || (state_q == S_WR);
    done       = (state_q == S_DONE);
    words_done = wd_q;
    ram_we     = (state_q == S_WR);
    ram_addr   = '0;
    ram_data   = '0;
    if (state_q == S_RD) begin
      ram_addr = rd_addr;
    end else if (state_q == S_WR) begin
      ram_addr = wr_addr;
      ram_data = mode_q ? fill_q : ram_q;
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural 64x8 RAM attached.
//
// Handshake: start is a one-cycle strobe taken only in IDLE; done is a
// one-cycle pulse; the RAM port is owned by the engine whenever busy is high.
module tb_ram_copy_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [5:0] src_addr;
  logic [5:0] dst_addr;
  logic [6:0] len;
  logic [7:0] fill_data;
  logic       busy;
  logic       done;
  logic [6:0] words_done;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  // RAM model plus backdoor preload port
  logic [7:0] mem [64];
  logic [5:0] rd_addr_q;
  logic       tb_we = 1'b0;
  logic [5:0] tb_addr = '0;
  logic [7:0] tb_data = '0;

  // write monitor
  logic       clr_mon = 1'b0;
  int         we_cnt;
  logic       first_seen;
  logic [5:0] first_addr;
  logic [7:0] first_data;

  int n_checks = 0;
  int n_fail   = 0;
  int dcyc;

  ram_copy_engine #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_data  (fill_data),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_q      (ram_q)
  );

  // clock / reset
  always #5 clk = ~clk;

  // single-port RAM: registered read address
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else if (tb_we) mem[tb_addr] <= tb_data;
    rd_addr_q <= ram_addr;
  end
  assign ram_q = mem[rd_addr_q];

  // count writes and capture the first one of each command
  always @(negedge clk) begin
    if (clr_mon) begin
      we_cnt     <= 0;
      first_seen <= 1'b0;
      first_addr <= '0;
      first_data <= '0;
    end else if (ram_we) begin
      we_cnt <= we_cnt + 1;
      if (!first_seen) begin
        first_seen <= 1'b1;
        first_addr <= ram_addr;
        first_data <= ram_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] a, input logic [7:0] d);
    tb_we   = 1'b1;
    tb_addr = a;
    tb_data = d;
    tick();
    tb_we   = 1'b0;
  endtask

  // present a command and let edge 0 sample it; returns in cycle 1
  task automatic issue(input logic m, input logic [5:0] s, input logic [5:0] d,
                       input logic [6:0] l, input logic [7:0] f);
    clr_mon   = 1'b1;
    start     = 1'b1;
    mode      = m;
    src_addr  = s;
    dst_addr  = d;
    len       = l;
    fill_data = f;
    tick();
    start   = 1'b0;
    clr_mon = 1'b0;
  endtask

  // run a command; dc = cycle in which done was seen (0 if never).
  // A non-zero poke_cyc drives a competing start in that cycle.
  task automatic run_cmd(input logic m, input logic [5:0] s, input logic [5:0] d,
                         input logic [6:0] l, input logic [7:0] f,
                         input int poke_cyc, output int dc);
    issue(m, s, d, l, f);
    dc = 0;
    for (int k = 1; k < 300; k++) begin
      start = 1'b0;
      if (done) begin
        dc = k;
        break;
      end
      if (k == poke_cyc) begin
        start     = 1'b1;
        mode      = 1'b1;
        src_addr  = 6'd0;
        dst_addr  = 6'd50;
        len       = 7'd5;
        fill_data = 8'hFF;
      end
      tick();
    end
    start = 1'b0;
    tick();
    check("back_to_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_data = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    tick();
    tick();
    // reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_words_done", {25'd0, words_done}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {26'd0, ram_addr}, 32'd0);
    check("rst_ram_data", {24'd0, ram_data}, 32'd0);
    rst = 1'b0;
    tick();

    // fill dst=10 len=4 with 0xA5
    poke(6'd14, 8'h3C);
    run_cmd(1'b1, 6'd0, 6'd10, 7'd4, 8'hA5, 0, dcyc);
    check("fill_done_cycle", dcyc, 32'd5);
    check("fill_words_done", {25'd0, words_done}, 32'd4);
    check("fill_we_cnt", we_cnt, 32'd4);
    for (int i = 10; i < 14; i++) check("fill_word", {24'd0, mem[i]}, 32'hA5);
    check("fill_untouched14", {24'd0, mem[14]}, 32'h3C);

    // ascending copy 0..3 -> 40..43
    poke(6'd0, 8'h11); poke(6'd1, 8'h22); poke(6'd2, 8'h33); poke(6'd3, 8'h44);
    run_cmd(1'b0, 6'd0, 6'd40, 7'd4, 8'h00, 0, dcyc);
    check("asc_done_cycle", dcyc, 32'd9);
    check("asc_we_cnt", we_cnt, 32'd4);
    check("asc_first_addr", {26'd0, first_addr}, 32'd40);
    check("asc_first_data", {24'd0, first_data}, 32'h11);
    check("asc_m40", {24'd0, mem[40]}, 32'h11);
    check("asc_m41", {24'd0, mem[41]}, 32'h22);
    check("asc_m42", {24'd0, mem[42]}, 32'h33);
    check("asc_m43", {24'd0, mem[43]}, 32'h44);

    // overlapping descending copy 5..8 -> 7..10
    poke(6'd5, 8'd1); poke(6'd6, 8'd2); poke(6'd7, 8'd3); poke(6'd8, 8'd4);
    poke(6'd9, 8'hEE); poke(6'd10, 8'hEE);
    run_cmd(1'b0, 6'd5, 6'd7, 7'd4, 8'h00, 0, dcyc);
    check("desc_done_cycle", dcyc, 32'd9);
    check("desc_first_addr", {26'd0, first_addr}, 32'd10);
    check("desc_first_data", {24'd0, first_data}, 32'd4);
    check("desc_m7", {24'd0, mem[7]}, 32'd1);
    check("desc_m8", {24'd0, mem[8]}, 32'd2);
    check("desc_m9", {24'd0, mem[9]}, 32'd3);
    check("desc_m10", {24'd0, mem[10]}, 32'd4);

    // wrap: copy 62,63 -> 0,1 then fill 63,0
    poke(6'd62, 8'h77); poke(6'd63, 8'h88);
    run_cmd(1'b0, 6'd62, 6'd0, 7'd2, 8'h00, 0, dcyc);
    check("wrap_copy_m0", {24'd0, mem[0]}, 32'h77);
    check("wrap_copy_m1", {24'd0, mem[1]}, 32'h88);
    run_cmd(1'b1, 6'd0, 6'd63, 7'd2, 8'h5A, 0, dcyc);
    check("wrap_fill_done_cycle", dcyc, 32'd3);
    check("wrap_fill_m63", {24'd0, mem[63]}, 32'h5A);
    check("wrap_fill_m0", {24'd0, mem[0]}, 32'h5A);
    check("wrap_fill_m1", {24'd0, mem[1]}, 32'h88);

    // len = 0
    run_cmd(1'b0, 6'd3, 6'd20, 7'd0, 8'h00, 0, dcyc);
    check("len0_done_cycle", dcyc, 32'd1);
    check("len0_we_cnt", we_cnt, 32'd0);
    check("len0_words_done", {25'd0, words_done}, 32'd0);

    // start while busy is ignored
    poke(6'd20, 8'hC1); poke(6'd21, 8'hC2); poke(6'd22, 8'hC3);
    poke(6'd50, 8'h00);
    run_cmd(1'b0, 6'd20, 6'd30, 7'd3, 8'h00, 2, dcyc);
    check("busy_start_done_cycle", dcyc, 32'd7);
    check("busy_start_we_cnt", we_cnt, 32'd3);
    check("busy_start_words_done", {25'd0, words_done}, 32'd3);
    check("busy_start_m30", {24'd0, mem[30]}, 32'hC1);
    check("busy_start_m31", {24'd0, mem[31]}, 32'hC2);
    check("busy_start_m32", {24'd0, mem[32]}, 32'hC3);
    check("busy_start_m50", {24'd0, mem[50]}, 32'h00);

    // full-depth copy onto itself leaves memory unchanged
    run_cmd(1'b0, 6'd0, 6'd0, 7'd64, 8'h00, 0, dcyc);
    check("len64_done_cycle", dcyc, 32'd129);
    check("len64_we_cnt", we_cnt, 32'd64);
    check("len64_words_done", {25'd0, words_done}, 32'd64);
    check("len64_m0", {24'd0, mem[0]}, 32'h5A);
    check("len64_m63", {24'd0, mem[63]}, 32'h5A);
    check("len64_m31", {24'd0, mem[31]}, 32'hC2);

    // reset after two words of an 8-word copy
    for (int i = 0; i < 8; i++) poke(6'(i), 8'h80 + 8'(i));
    for (int i = 48; i < 56; i++) poke(6'(i), 8'h00);
    issue(1'b0, 6'd0, 6'd48, 7'd8, 8'h00);
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ram_we", {31'd0, ram_we}, 32'd0);
    check("abort_words_done", {25'd0, words_done}, 32'd0);
    dcyc = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dcyc++;
      tick();
    end
    check("abort_no_done", dcyc, 32'd0);
    check("abort_we_cnt", we_cnt, 32'd2);
    check("abort_m48", {24'd0, mem[48]}, 32'h80);
    check("abort_m49", {24'd0, mem[49]}, 32'h81);
    check("abort_m50", {24'd0, mem[50]}, 32'h00);
    check("abort_m55", {24'd0, mem[55]}, 32'h00);
    run_cmd(1'b1, 6'd0, 6'd60, 7'd2, 8'h3E, 0, dcyc);
    check("after_abort_done_cycle", dcyc, 32'd3);
    check("after_abort_m60", {24'd0, mem[60]}, 32'h3E);
    check("after_abort_m61", {24'd0, mem[61]}, 32'h3E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
